// File: rtl/hamming32t26d_pkg.sv
// Shared constants, codeword layout and helpers for the 32-bit SECDED decoder
// (26 data bits, 5 Hamming check bits, overall parity in bit 0).
package hamming32t26d_pkg;

    localparam int IN_WIDTH = 26;
    localparam int N_CHECKB = 5;
    localparam int CW_WIDTH = 32;

    // Codeword position of each data bit; powers of two and bit 0 hold check bits.
    localparam logic [4:0] DATA_POS [IN_WIDTH] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SEC,
        ERR_DED
    } err_kind_e;

    function automatic logic [IN_WIDTH-1:0] extract_data(input logic [CW_WIDTH-1:0] cw);
        logic [IN_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

    function automatic err_kind_e classify(input logic [N_CHECKB-1:0] s, input logic p);
        err_kind_e k;
        if (p)
            k = ERR_SEC;
        else if (s != '0)
            k = ERR_DED;
        else
            k = ERR_NONE;
        return k;
    endfunction

endpackage

// File: rtl/hamming32t26d_syndrome.sv
// Combinational syndrome and overall-parity generator for one codeword.
module hamming32t26d_syndrome
    import hamming32t26d_pkg::*;
(
    input  logic [CW_WIDTH-1:0] hv,
    output logic [N_CHECKB-1:0] s,
    output logic                p
);

    // Syndrome is the XOR of the indices of every set bit in positions 1..31.
    always_comb begin
        s = '0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if (hv[i])
                s = s ^ N_CHECKB'(i);
        end
        p = ^hv;
    end

endmodule

// File: rtl/hamming32t26d_dec.sv
// Two-stage pipelined SECDED decoder with valid/ready on both sides and
// saturating SEC/DED event counters.
module hamming32t26d_dec
    import hamming32t26d_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CW_WIDTH-1:0]  hv_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [IN_WIDTH-1:0]  data_o,
    output logic                 sec_o,
    output logic                 ded_o,
    output logic [N_CHECKB-1:0]  syndrome_o,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] sec_cnt_o,
    output logic [CNT_WIDTH-1:0] ded_cnt_o
);

    logic                 adv1, adv2, out_xfer;
    logic [N_CHECKB-1:0]  syn_c;
    logic                 par_c;

    logic                 s1_valid_q, s1_valid_d;
    logic [CW_WIDTH-1:0]  s1_cw_q, s1_cw_d;
    logic [N_CHECKB-1:0]  s1_syn_q, s1_syn_d;
    logic                 s1_par_q, s1_par_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [IN_WIDTH-1:0]  data_q, data_d;
    logic                 sec_q, sec_d;
    logic                 ded_q, ded_d;
    logic [N_CHECKB-1:0]  syn_q, syn_d;
    logic [CW_WIDTH-1:0]  corrected;
    err_kind_e            kind;

    logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;

    assign adv2     = !s2_valid_q || ready_i;
    assign adv1     = !s1_valid_q || adv2;
    assign ready_o  = adv1;
    assign out_xfer = s2_valid_q && ready_i;

    hamming32t26d_syndrome u_syndrome (
        .hv (hv_i),
        .s  (syn_c),
        .p  (par_c)
    );

    // Stage 1: capture codeword with its syndrome and overall parity.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (adv1) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_cw_d  = hv_i;
                s1_syn_d = syn_c;
                s1_par_d = par_c;
            end
        end
    end

    // Stage 2: classify, correct a single flipped bit (s=0 targets bit 0), extract data.
    always_comb begin
        kind      = classify(s1_syn_q, s1_par_q);
        corrected = s1_cw_q;
        if (kind == ERR_SEC)
            corrected = s1_cw_q ^ (CW_WIDTH'(1) << s1_syn_q);
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        sec_d      = sec_q;
        ded_d      = ded_q;
        syn_d      = syn_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d = extract_data(corrected);
                sec_d  = (kind == ERR_SEC);
                ded_d  = (kind == ERR_DED);
                syn_d  = s1_syn_q;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (clear_i) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_xfer) begin
            if (sec_q && sec_cnt_q != '1)
                sec_cnt_d = sec_cnt_q + CNT_WIDTH'(1);
            if (ded_q && ded_cnt_q != '1)
                ded_cnt_d = ded_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        s1_cw_q  <= s1_cw_d;
        s1_syn_q <= s1_syn_d;
        s1_par_q <= s1_par_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
            syn_q      <= '0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            sec_q      <= sec_d;
            ded_q      <= ded_d;
            syn_q      <= syn_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign valid_o    = s2_valid_q;
    assign data_o     = data_q;
    assign sec_o      = sec_q;
    assign ded_o      = ded_q;
    assign syndrome_o = syn_q;
    assign sec_cnt_o  = sec_cnt_q;
    assign ded_cnt_o  = ded_cnt_q;

endmodule

// File: tb/tb_hamming32t26d_dec.sv
// Bench for hamming32t26d_dec: directed vector table, hand-written handshake and
// counter sequences, and a randomized stream checked against a codeword model.
module tb_hamming32t26d_dec;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i, valid_i, ready_i, clear_i;
    logic [31:0]       hv_i;
    logic              ready_o, valid_o, sec_o, ded_o;
    logic [25:0]       data_o;
    logic [4:0]        syndrome_o;
    logic [CNT_W-1:0]  sec_cnt_o, ded_cnt_o;

    hamming32t26d_dec #(.CNT_WIDTH(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .hv_i(hv_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .sec_o(sec_o), .ded_o(ded_o), .syndrome_o(syndrome_o), .clear_i(clear_i),
        .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] hv;
        logic [25:0] data;
        logic        sec;
        logic        ded;
        logic [4:0]  syn;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   model_sec = 0;
    int   model_ded = 0;
    int   out_cnt = 0;
    bit   sb_en = 1'b0;
    bit   stall_seen = 1'b0;
    vec_t held;
    vec_t cur_exp;
    vec_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Reference encoder: data fills non-power-of-two positions in order; check
    // bit k is even parity over every position whose index has bit k set.
    function automatic logic [31:0] encode(input logic [25:0] d);
        logic [31:0] cw;
        logic        par;
        int          j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos < 32; pos++) begin
            if (!is_pow2(pos)) begin
                cw[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < 32; pos++)
                if (pos[k] && !is_pow2(pos)) par ^= cw[pos];
            cw[1 << k] = par;
        end
        cw[0] = ^cw[31:1];
        return cw;
    endfunction

    function automatic logic [25:0] extract(input logic [31:0] cw);
        logic [25:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < 32; pos++) begin
            if (!is_pow2(pos)) begin
                d[j] = cw[pos];
                j++;
            end
        end
        return d;
    endfunction

    // Flipping bit q of a clean codeword yields syndrome q; two flips yield q1^q2.
    function automatic vec_t make_vec(input logic [25:0] d, input int nerr);
        vec_t v;
        int   q1, q2;
        logic [31:0] cw;
        cw    = encode(d);
        v.data = d;
        v.sec = 1'b0;
        v.ded = 1'b0;
        v.syn = 5'd0;
        if (nerr == 1) begin
            q1 = $urandom_range(0, 31);
            cw[q1] = ~cw[q1];
            v.sec = 1'b1;
            v.syn = 5'(q1);
        end else if (nerr == 2) begin
            q1 = $urandom_range(0, 31);
            q2 = (q1 + $urandom_range(1, 31)) % 32;
            cw[q1] = ~cw[q1];
            cw[q2] = ~cw[q2];
            v.ded = 1'b1;
            v.syn = 5'(q1 ^ q2);
            v.data = extract(cw);
        end
        v.hv = cw;
        return v;
    endfunction

    // Monitor: counter model, stall stability and in-order scoreboard.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sbq.delete();
            model_sec = 0;
            model_ded = 0;
            stall_seen = 1'b0;
        end else begin
            chk("sec_cnt", 32'(sec_cnt_o), model_sec);
            chk("ded_cnt", 32'(ded_cnt_o), model_ded);
            if (stall_seen) begin
                chk("stall_valid", 32'(valid_o), 1);
                chk("stall_data", 32'(data_o), 32'(held.data));
                chk("stall_flags", {syndrome_o, sec_o, ded_o}, {held.syn, held.sec, held.ded});
            end
            stall_seen = valid_o && !ready_i;
            held.data = data_o;
            held.sec  = sec_o;
            held.ded  = ded_o;
            held.syn  = syndrome_o;
            if (sb_en && valid_i && ready_o)
                sbq.push_back(cur_exp);
            if (valid_o && ready_i) begin
                if (sb_en) begin
                    out_cnt++;
                    if (sbq.size() == 0) begin
                        chk("sb_extra_output", 32'(out_cnt), 32'(0));
                    end else begin
                        vec_t e;
                        e = sbq.pop_front();
                        chk("sb_data", 32'(data_o), 32'(e.data));
                        chk("sb_sec", 32'(sec_o), 32'(e.sec));
                        chk("sb_ded", 32'(ded_o), 32'(e.ded));
                        chk("sb_syn", 32'(syndrome_o), 32'(e.syn));
                    end
                end
                if (sec_o && model_sec < CNT_MAX) model_sec++;
                if (ded_o && model_ded < CNT_MAX) model_ded++;
            end
            if (clear_i) begin
                model_sec = 0;
                model_ded = 0;
            end
        end
    end

    // Called at posedge+1 with the pipeline empty and ready_i=1.
    task automatic send_and_check(input vec_t v);
        valid_i = 1'b1;
        hv_i    = v.hv;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("lat_not_early", 32'(valid_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("tbl_valid", 32'(valid_o), 1);
        chk("tbl_data", 32'(data_o), 32'(v.data));
        chk("tbl_sec", 32'(sec_o), 32'(v.sec));
        chk("tbl_ded", 32'(ded_o), 32'(v.ded));
        chk("tbl_syn", 32'(syndrome_o), 32'(v.syn));
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t w[4];
        int   idx;
        bit   accepted;

        tbl[0] = '{32'h0000_0000, 26'h000_0000, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{32'hFFFF_EFFF, 26'h3FF_FFFF, 1'b1, 1'b0, 5'd12};
        tbl[2] = '{32'h0000_0001, 26'h000_0000, 1'b1, 1'b0, 5'd0};
        tbl[3] = '{32'h0000_0028, 26'h000_0003, 1'b0, 1'b1, 5'd6};
        tbl[4] = '{32'h0000_0008, 26'h000_0000, 1'b1, 1'b0, 5'd3};
        tbl[5] = '{32'h8000_0000, 26'h000_0000, 1'b1, 1'b0, 5'd31};
        tbl[6] = '{32'h0000_0003, 26'h000_0000, 1'b0, 1'b1, 5'd1};

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0; hv_i = '0;
        cur_exp = tbl[0];
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_flags", {syndrome_o, sec_o, ded_o}, 0);
        chk("rst_cnts", {sec_cnt_o, ded_cnt_o}, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send_and_check(tbl[i]);
            if (i == 1) chk("sec_cnt_first", 32'(sec_cnt_o), 1);
            if (i == 3) chk("ded_cnt_first", 32'(ded_cnt_o), 1);
        end

        // Saturation: clear, then five SEC words back to back.
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("clear_cnt", 32'(sec_cnt_o), 0);
        for (int k = 0; k < 5; k++) begin
            vec_t v;
            v = make_vec(26'($urandom), 1);
            valid_i = 1'b1;
            hv_i    = v.hv;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("sec_saturate", 32'(sec_cnt_o), CNT_MAX);

        // Clear in the same cycle as a SEC output transfer.
        w[0] = make_vec(26'($urandom), 1);
        valid_i = 1'b1;
        hv_i    = w[0].hv;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("clr_inc_valid", 32'(valid_o), 1);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("clear_wins", 32'(sec_cnt_o), 0);

        // Backpressure: four words, ready_i low for cycles 1..3.
        for (int k = 0; k < 4; k++) w[k] = make_vec(26'($urandom), k % 3);
        sb_en = 1'b1;
        out_cnt = 0;
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            valid_i = (idx < 4);
            if (idx < 4) begin
                hv_i    = w[idx].hv;
                cur_exp = w[idx];
            end
            ready_i = !(cyc >= 1 && cyc <= 3);
            @(negedge clk_i);
            if (cyc == 2) chk("bp_ready_low", 32'(ready_o), 0);
            if (valid_i && ready_o) idx++;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        chk("bp_all_sent", 32'(idx), 4);
        chk("bp_out_count", 32'(out_cnt), 4);
        chk("bp_sb_empty", 32'(sbq.size()), 0);

        // Randomized stream with random backpressure and occasional clears.
        accepted = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!valid_i || accepted) begin
                valid_i = ($urandom_range(0, 3) != 0);
                cur_exp = make_vec(26'($urandom), $urandom_range(0, 2));
                hv_i    = cur_exp.hv;
            end
            ready_i = ($urandom_range(0, 3) != 0);
            clear_i = ($urandom_range(0, 31) == 0);
            @(negedge clk_i);
            accepted = valid_i && ready_o;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        clear_i = 1'b0;
        for (int k = 0; k < 20 && sbq.size() != 0; k++) begin
            @(posedge clk_i); #1;
        end
        chk("rand_drain", 32'(sbq.size()), 0);

        // Reset mid-stream drops in-flight words with no replay.
        for (int k = 0; k < 2; k++) begin
            cur_exp = make_vec(26'($urandom), 1);
            valid_i = 1'b1;
            hv_i    = cur_exp.hv;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        chk("midrst_valid", 32'(valid_o), 0);
        chk("midrst_cnt", {sec_cnt_o, ded_cnt_o}, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("no_replay", 32'(valid_o), 0);
        end
        sb_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
